// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Loads hit in the same cycle; misses and all stores stall until main memory completes.
module dcache #(
    parameter int unsigned SETS = 16,
    parameter int unsigned IDXW = $clog2(SETS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);
    localparam int unsigned TAGW = 30 - IDXW;

    typedef enum logic [1:0] {S_IDLE, S_RDMISS, S_WRITE} state_t;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [TAGW-1:0]   r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic              r_mem_req;
    logic              r_mem_we;
    logic [29:0]       r_mem_waddr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic              w_hit;
    logic [IDXW-1:0]   w_lidx;
    logic [TAGW-1:0]   w_ltag;
    logic              w_lhit;
    logic              w_unused;

    assign w_idx    = addr_i[IDXW+1:2];
    assign w_tag    = addr_i[31:IDXW+2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // The latched memory address doubles as the pending-access address.
    assign w_lidx   = r_mem_waddr[IDXW-1:0];
    assign w_ltag   = r_mem_waddr[29:IDXW];
    assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_unused = ^addr_i[1:0];

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = {r_mem_waddr, 2'b00};
    assign mem_wdata_o = r_mem_wdata;
    assign hit_cnt_o   = r_hit_cnt;
    assign miss_cnt_o  = r_miss_cnt;

    // Same-cycle stall and load data; forced quiet while reset is asserted.
    always_comb begin
        stall_o = 1'b0;
        rdata_o = 32'd0;
        if (rst_i) begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        if (we_i || !w_hit) stall_o = 1'b1;
                        else                rdata_o = r_data[w_idx];
                    end
                end
                S_RDMISS: begin
                    if (mem_ready_i) rdata_o = mem_rdata_i;
                    else             stall_o = 1'b1;
                end
                S_WRITE: stall_o = !mem_ready_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    // Control FSM, memory port registers, valid bits and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= 30'd0;
            r_mem_wdata <= 32'd0;
            r_hit_cnt   <= 32'd0;
            r_miss_cnt  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        if (we_i) begin
                            r_state     <= S_WRITE;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= addr_i[31:2];
                            r_mem_wdata <= wdata_i;
                        end else if (w_hit) begin
                            r_hit_cnt   <= r_hit_cnt + 32'd1;
                        end else begin
                            r_state     <= S_RDMISS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_waddr <= addr_i[31:2];
                            r_miss_cnt  <= r_miss_cnt + 32'd1;
                        end
                    end
                end
                S_RDMISS: begin
                    if (mem_ready_i) begin
                        r_valid[w_lidx] <= 1'b1;
                        r_mem_req       <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready_i) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays; write hits update data only, write misses do not allocate.
    always_ff @(posedge clk_i) begin
        if (r_state == S_RDMISS && mem_ready_i) begin
            r_tag[w_lidx]  <= w_ltag;
            r_data[w_lidx] <= mem_rdata_i;
        end else if (r_state == S_WRITE && mem_ready_i && w_lhit) begin
            r_data[w_lidx] <= r_mem_wdata;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed scenarios plus randomized traffic checked against
// a word-addressed behavioural cache/memory model.
module tb_dcache;
    localparam int unsigned SETS = 16;
    localparam int unsigned IDXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    dcache #(.SETS(SETS)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: lines remember the full word address they hold.
    bit          m_valid [SETS];
    logic [29:0] m_line  [SETS];
    logic [31:0] m_data  [SETS];
    int unsigned m_hits;
    int unsigned m_misses;
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return 32'(wa) * 32'h9E3779B1 + 32'h1357;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(SETS); i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One CPU access; the bench plays main memory with wait_n wait cycles.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int wait_n);
        logic [29:0] wa;
        int          idx;
        bit          hit;
        logic [31:0] rv;
        wa  = a[31:2];
        idx = int'(wa[IDXW-1:0]);
        hit = m_valid[idx] && (m_line[idx] == wa);
        rv  = mem_rd(wa);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        if (!w && hit) begin
            chk("hit_stall", 32'(stall), 32'd0);
            chk("hit_rdata", rdata, m_data[idx]);
            m_hits++;
        end else begin
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_rdata", rdata, 32'd0);
            if (!w) m_misses++;
            for (int k = 0; k <= wait_n; k++) begin
                @(negedge clk);
                mem_ready = (k == wait_n);
                mem_rdata = mem_ready ? rv : $urandom;
                #1;
                chk("mem_req", 32'(mem_req), 32'd1);
                chk("mem_we", 32'(mem_we), 32'(w));
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                if (w) chk("mem_wdata", mem_wdata, d);
                chk("acc_stall", 32'(stall), (k == wait_n) ? 32'd0 : 32'd1);
                chk("acc_rdata", rdata, (!w && k == wait_n) ? rv : 32'd0);
            end
            if (w) begin
                mem[wa] = d;
                if (hit) m_data[idx] = d;
            end else begin
                m_valid[idx] = 1'b1;
                m_line[idx]  = wa;
                m_data[idx]  = rv;
            end
        end
    endtask

    // Idle cycle with random noise on memory and CPU lines.
    task automatic idle();
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_rdata", rdata, 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
    endtask

    logic [25:0] tag_pool [4];

    initial begin
        tag_pool[0] = 26'h0000004; tag_pool[1] = 26'h0000005;
        tag_pool[2] = 26'h0000008; tag_pool[3] = 26'h2000000;
        model_reset();
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h100; wdata = 32'd0;
        mem_ready = 1'b1; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_hit", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        @(negedge clk);
        req = 1'b0; mem_ready = 1'b0;
        rst_n = 1'b1;

        mem[30'h40] = 32'hDEADBEEF;
        access(1'b0, 32'h100, 32'd0, 2);
        access(1'b0, 32'h100, 32'd0, 0);
        access(1'b1, 32'h100, 32'h12345678, 1);
        access(1'b0, 32'h100, 32'd0, 0);
        access(1'b1, 32'h200, 32'hCAFEF00D, 0);
        access(1'b0, 32'h200, 32'd0, 0);
        access(1'b0, 32'h203, 32'd0, 0);
        access(1'b0, 32'h140, 32'd0, 1);
        access(1'b0, 32'h100, 32'd0, 0);
        access(1'b1, 32'h100, 32'hA5A55A5A, 0);
        access(1'b0, 32'h100, 32'd0, 0);
        repeat (4) idle();

        // Reset in the middle of a read miss.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h140; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_hit", hit_cnt, 32'd0);
        chk("mid_rst_miss", miss_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        access(1'b0, 32'h100, 32'd0, 0);
        access(1'b0, 32'h140, 32'd0, 0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int r;
            r = int'($urandom_range(0, 9));
            a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (r == 0) idle();
            else access(1'(r < 4), a, $urandom, int'($urandom_range(0, 3)));
        end
        access(1'b0, 32'h0, 32'd0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
